shift_add_mul_ctrl: RTL and testbench

Sequential shift-and-add multiplier controller. It time-shares one W-bit ripple-carry adder across W iterations to form an unsigned W×W → 2W product. A start/busy/done handshake sequences the work, one multiplier bit per clock. It sits beside the adder datapath, so the lab ALU can multiply without a W×W array.

---
 rtl/shift_add_mul_ctrl_pkg.sv | 18 +
 rtl/shift_add_mul_ctrl_adder.sv | 25 ++
 rtl/shift_add_mul_ctrl.sv | 143 ++++++++++++++
 tb/tb_shift_add_mul_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller.
package mul_ctrl_pkg;

    localparam int unsigned MUL_WIDTH_DEFAULT = 8;

    // Code 2'b11 is unused; the controller recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    // Iteration counter width: must hold the value WIDTH itself.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_mul_ctrl_adder.sv
// WIDTH-bit ripple-carry adder built from full-adder cells.
module mul_acc_adder
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             cout,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential shift-and-add multiplier controller: one multiplier bit per
// clock through a single shared WIDTH-bit adder, start/busy/done handshake.
// Optional macro SHIFT_ADD_MUL_EARLY_TERM_EN: finish as soon as the
// unconsumed multiplier bits are all zero, realigning the product.
module shift_add_mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH_DEFAULT,
    parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem_mask;
`endif

    assign addend = q_q[0] ? m_q : '0;

    // C is always cleared by the shift, so feeding it as carry-in keeps cin at 0.
    mul_acc_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (a_q),
        .b    (addend),
        .cin  (c_q),
        .cout (cout),
        .sum  (sum)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            c_q       <= c_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        c_d       = c_q;
        count_d   = count_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        rem_mask  = '0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    c_d     = 1'b0;
                    count_d = CNT_W'(WIDTH);
                    state_d = RUN;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
                    if (multiplier == '0) begin
                        product_d = '0;
                        state_d   = DONE;
                    end
`endif
                end
            end

            RUN: begin
                busy    = 1'b1;
                c_d     = 1'b0;
                a_d     = {cout, sum[WIDTH-1:1]};
                q_d     = {sum[0], q_q[WIDTH-1:1]};
                count_d = count_q - 1'b1;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
                // Low count_d bits of the shifted Q are the multiplier bits
                // still to be consumed; if none are set, the skipped
                // iterations would only shift, so shift once on load instead.
                rem_mask = ~({WIDTH{1'b1}} << count_d);
                if ((count_q == CNT_W'(1)) || ((q_d & rem_mask) == '0)) begin
                    product_d = {a_d, q_d} >> count_d;
                    state_d   = DONE;
                end
`else
                if (count_q == CNT_W'(1)) begin
                    product_d = {a_d, q_d};
                    state_d   = DONE;
                end
`endif
            end

            DONE: begin
                // Product was loaded on the edge entering DONE, so it is
                // already valid while done is high.
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed self-checking bench for shift_add_mul_ctrl (WIDTH=8).
module tb_shift_add_mul_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    localparam int L_13X11  = 5;
    localparam int L_255SQ  = 9;
    localparam int L_200X3  = 3;
    localparam int L_1X1    = 2;
    localparam int L_7X9    = 5;
    localparam int L_5X0    = 1;
`else
    localparam int L_13X11  = 9;
    localparam int L_255SQ  = 9;
    localparam int L_200X3  = 9;
    localparam int L_1X1    = 9;
    localparam int L_7X9    = 9;
    localparam int L_5X0    = 9;
`endif

    shift_add_mul_ctrl #(
        .WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one multiply; latency counts clock edges from the accepting edge
    // (inclusive) until done is seen. Optional ignored re-pulses of 1x1.
    task automatic run_mul(input string tag, input logic [7:0] m, input logic [7:0] q,
                           input logic [15:0] exp_p, input int exp_lat, input bit repulse);
        int lat;
        bit seen;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 8'hA5;
        multiplier   = 8'h5A;
        lat  = 0;
        seen = 1'b0;
        for (int j = 1; j <= 24 && !seen; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat  = j;
                seen = 1'b1;
            end else if (repulse && (j == 3 || j == 5) && j < exp_lat) begin
                start        = 1'b1;
                multiplicand = 8'd1;
                multiplier   = 8'd1;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_with_done"}, busy, 1'b1);
        chk({tag, "_product"}, product, exp_p);
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, done, 1'b0);
        chk({tag, "_busy_fall"}, busy, 1'b0);
        chk({tag, "_product_held"}, product, exp_p);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // Reset for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_product", product, 16'h0000);
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        run_mul("m13x11",  8'd13,  8'd11,  16'h008F, L_13X11, 1'b0);
        run_mul("m255x255", 8'd255, 8'd255, 16'hFE01, L_255SQ, 1'b0);
        run_mul("m200x3_repulse", 8'd200, 8'd3, 16'h0258, L_200X3, 1'b1);
        run_mul("m1x1", 8'd1, 8'd1, 16'h0001, L_1X1, 1'b0);

        // Reset during RUN: operation discarded, no done, product cleared.
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("rst_mid_no_done", done, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_product", product, 16'h0000);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("rst_mid_quiet", done, 1'b0);
        end

        run_mul("m7x9", 8'd7, 8'd9, 16'h003F, L_7X9, 1'b0);
        run_mul("m5x0", 8'd5, 8'd0, 16'h0000, L_5X0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
